// File: rtl/pixel_fb_writer.sv
// Framebuffer write stage: filters rasterizer pixels, maps (x, y) to a linear
// byte address and queues writes through a small FIFO to one memory write port.
module pixel_fb_writer #(
   parameter int H_RES      = 800,
   parameter int V_RES      = 600,
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic [10:0]       in_x,
   input  logic [10:0]       in_y,
   input  logic              in_draw,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              frame_start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [19:0]       pixel_count,
   output logic [19:0]       drop_count,
   output logic              idle
);

   localparam int IDX_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int ENT_W = ADDR_W + 8;
   localparam logic [19:0] CNT_MAX = '1;

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic              fifo_full, fifo_empty;
   logic              accept, on_screen, push, drop, pop;
   logic [ADDR_W-1:0] y_a, x_a, lin_addr;
   logic [ENT_W-1:0]  head;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                       (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

   assign in_ready  = !fifo_full && reset;
   assign accept    = in_valid && in_ready;
   assign on_screen = (32'(in_x) < H_RES) && (32'(in_y) < V_RES);
   assign push      = accept && in_draw && on_screen;
   assign drop      = accept && in_draw && !on_screen;

   // Arithmetic is done modulo 2^ADDR_W; truncating the operands up front
   // gives the same low bits as truncating the full product.
   assign y_a = ADDR_W'(in_y);
   assign x_a = ADDR_W'(in_x);

   generate
      if (H_RES == 800) begin : g_addr_shift
         assign lin_addr = (y_a << 9) + (y_a << 8) + (y_a << 5) + x_a;
      end else begin : g_addr_mul
         assign lin_addr = y_a * ADDR_W'(H_RES) + x_a;
      end
   endgenerate

   // mem_we is gated by reset so the port goes quiet in the reset cycle itself,
   // before the synchronous pointer clear has taken effect.
   assign head      = fifo_mem[rd_ptr[IDX_W-1:0]];
   assign mem_addr  = head[ENT_W-1:8];
   assign mem_wdata = head[7:0];
   assign mem_we    = !fifo_empty && reset;
   assign pop       = mem_we && mem_ready;
   assign idle      = fifo_empty || !reset;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // NOTE: FIFO storage is not reset; the pointers alone define which entries
   // are valid, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= {lin_addr, in_data};
   end

   // frame_start clears with priority, so a coinciding increment is lost.
   always_ff @(posedge clk) begin
      if (!reset || frame_start) begin
         pixel_count <= '0;
         drop_count  <= '0;
      end else begin
         if (pop && pixel_count != CNT_MAX)  pixel_count <= pixel_count + 20'd1;
         if (drop && drop_count != CNT_MAX)  drop_count  <= drop_count + 20'd1;
      end
   end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer: scoreboard of expected writes plus
// per-scenario tasks covering filtering, back-pressure, frame_start and reset.
module tb_pixel_fb_writer;

   localparam int ADDR_W = 19;
   localparam int PMAX   = 20'hFFFFF;

   logic              clk;
   logic              reset;
   logic [7:0]        in_data;
   logic [10:0]       in_x, in_y;
   logic              in_draw, in_valid, in_ready;
   logic              frame_start;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we, mem_ready;
   logic [19:0]       pixel_count, drop_count;
   logic              idle;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W+7:0] sb [$];
   int                exp_pix  = 0;
   int                exp_drop = 0;
   logic              toggle_en = 1'b0;
   logic              prev_stall = 1'b0;
   logic [ADDR_W-1:0] prev_addr;
   logic [7:0]        prev_data;

   pixel_fb_writer #(.H_RES(800), .V_RES(600), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_x(in_x), .in_y(in_y),
      .in_draw(in_draw), .in_valid(in_valid), .in_ready(in_ready),
      .frame_start(frame_start), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_ready(mem_ready), .pixel_count(pixel_count),
      .drop_count(drop_count), .idle(idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      #1;
      if (toggle_en) mem_ready = ~mem_ready;
   end

   // Memory-side monitor: checks every transfer against the scoreboard, the
   // hold-while-stalled rule, and keeps the expected pixel counter.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (prev_stall) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data) begin
               errors++;
               $display("FAIL hold_stable: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                        mem_we, mem_addr, mem_wdata, prev_addr, prev_data);
            end
         end
         if (mem_we === 1'b1 && mem_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_addr, mem_wdata);
            end else begin
               logic [ADDR_W+7:0] e;
               e = sb.pop_front();
               if ({mem_addr, mem_wdata} !== e) begin
                  errors++;
                  $display("FAIL write_order: addr=%0d data=%h, required addr=%0d data=%h",
                           mem_addr, mem_wdata, e[ADDR_W+7:8], e[7:0]);
               end
            end
            if (frame_start !== 1'b1 && exp_pix != PMAX) exp_pix++;
         end
         if (frame_start === 1'b1) begin
            exp_pix  = 0;
            exp_drop = 0;
         end
         prev_stall = (mem_we === 1'b1) && (mem_ready !== 1'b1);
         prev_addr  = mem_addr;
         prev_data  = mem_wdata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic drive_beat(input int x, input int y, input bit draw, input logic [7:0] d);
      bit done = 1'b0;
      in_x = 11'(x); in_y = 11'(y); in_draw = draw; in_data = d; in_valid = 1'b1;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            done = 1'b1;
            if (draw && x < 800 && y < 600)
               sb.push_back({ADDR_W'(y * 800 + x), d});
            else if (draw)
               exp_drop++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout: beat x=%0d y=%0d never accepted", x, y);
      end
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (idle === 1'b1 && sb.size() == 0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s_drain: idle=%b pending=%0d, required idle=1 pending=0", name, idle, sb.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
   endtask

   task automatic check_counts(input string name);
      @(negedge clk);
      checks++;
      if (pixel_count !== 20'(exp_pix) || drop_count !== 20'(exp_drop)) begin
         errors++;
         $display("FAIL %s_counts: pixel=%0d drop=%0d, required pixel=%0d drop=%0d",
                  name, pixel_count, drop_count, exp_pix, exp_drop);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: in_ready=%b mem_we=%b idle=%b, required 0 0 1", in_ready, mem_we, idle);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || pixel_count !== 20'd0 || drop_count !== 20'd0 || idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b pixel=%0d drop=%0d idle=%b, required 1 0 0 1",
                  in_ready, pixel_count, drop_count, idle);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      mem_ready = 1'b1;
      pulse_frame();
      drive_beat(5, 2, 1'b1, 8'h3C);
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 19'd1605 || mem_wdata !== 8'h3C) begin
         errors++;
         $display("FAIL single_latency: we=%b addr=%0d data=%h, required we=1 addr=1605 data=3c",
                  mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk); #1;
      wait_idle("single");
      check_counts("single");
      checks++;
      if (pixel_count !== 20'd1) begin
         errors++;
         $display("FAIL single_pixel_count: got %0d, required 1", pixel_count);
      end
   endtask

   task automatic test_filter();
      pulse_frame();
      drive_beat(10, 0, 1'b0, 8'h11);
      drive_beat(800, 0, 1'b1, 8'h22);
      drive_beat(0, 600, 1'b1, 8'h33);
      drive_beat(799, 599, 1'b1, 8'hFF);
      wait_idle("filter");
      check_counts("filter");
      checks++;
      if (pixel_count !== 20'd1 || drop_count !== 20'd2) begin
         errors++;
         $display("FAIL filter_totals: pixel=%0d drop=%0d, required 1 2", pixel_count, drop_count);
      end
   endtask

   task automatic test_back_pressure();
      pulse_frame();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive_beat(100 + i, 10 + i, 1'b1, 8'(8'hA0 + i));
      fork
         begin
            repeat (3) begin
               @(negedge clk);
               checks++;
               if (in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL backpressure_full: in_ready=%b, required 0", in_ready);
               end
            end
            @(posedge clk); #1;
            mem_ready = 1'b1;
         end
      join_none
      drive_beat(104, 14, 1'b1, 8'hA4);
      drive_beat(105, 15, 1'b1, 8'hA5);
      wait_idle("backpressure");
      check_counts("backpressure");
      checks++;
      if (pixel_count !== 20'd6) begin
         errors++;
         $display("FAIL backpressure_pixel_count: got %0d, required 6", pixel_count);
      end
   endtask

   task automatic test_hold();
      pulse_frame();
      mem_ready = 1'b0;
      toggle_en = 1'b1;
      for (int i = 0; i < 10; i++) drive_beat(3 * i, 500 + i, 1'b1, 8'(8'h50 + 7 * i));
      wait_idle("hold");
      toggle_en = 1'b0;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      check_counts("hold");
   endtask

   task automatic test_frame_start();
      pulse_frame();
      for (int i = 0; i < 7; i++) drive_beat(i, 1, 1'b1, 8'(i));
      wait_idle("fs_prefill");
      check_counts("fs_prefill");
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive_beat(20 + i, 30, 1'b1, 8'(8'hC0 + i));
      mem_ready   = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || pixel_count !== 20'd7) begin
         errors++;
         $display("FAIL fs_coincide_setup: we=%b pixel=%0d, required we=1 pixel=7", mem_we, pixel_count);
      end
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      checks++;
      if (pixel_count !== 20'd0) begin
         errors++;
         $display("FAIL fs_clear_wins: pixel=%0d, required 0", pixel_count);
      end
      @(posedge clk); #1;
      wait_idle("fs_drain");
      check_counts("fs_drain");
   endtask

   task automatic test_reset_mid();
      pulse_frame();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive_beat(400 + i, 300, 1'b1, 8'(8'hE0 + i));
      drive_beat(900, 5, 1'b1, 8'h01);
      check_counts("rst_pre");
      reset = 1'b0;
      sb.delete();
      exp_pix   = 0;
      exp_drop  = 0;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || in_ready !== 1'b0 || idle !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_outputs: we=%b in_ready=%b idle=%b, required 0 0 1", mem_we, in_ready, idle);
      end
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || mem_we !== 1'b0 || pixel_count !== 20'd0 || drop_count !== 20'd0) begin
         errors++;
         $display("FAIL rst_mid_release: in_ready=%b we=%b pixel=%0d drop=%0d, required 1 0 0 0",
                  in_ready, mem_we, pixel_count, drop_count);
      end
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_write: we=%b addr=%0d, required we=0", mem_we, mem_addr);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_draw = 1'b0; in_data = '0;
      in_x = '0; in_y = '0; frame_start = 1'b0; mem_ready = 1'b1;
      test_reset();
      test_single();
      test_filter();
      test_back_pressure();
      test_hold();
      test_frame_start();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_fb_writer.md
# pixel_fb_writer

Framebuffer write stage directly downstream of the rasterizer control block. Consumes its per-pixel stream (x, y, 8-bit colour, draw flag, valid/ready), drops non-drawn and off-screen pixels, converts (x, y) into a linear 800×600 byte address and issues writes to a single framebuffer write port. A small FIFO decouples rasterizer throughput from memory back-pressure. Per-frame written and dropped pixel counters are exported for software.

## Interface
- H_RES, 800, horizontal resolution in pixels
- V_RES, 600, vertical resolution in pixels
- ADDR_W, 19, framebuffer byte address width; must satisfy H_RES*V_RES ≤ 2^ADDR_W
- FIFO_DEPTH, 4, write FIFO entries; power of two, ≥ 2
- Clocking and reset: one clock; reset is synchronous and active-low.
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low (0 = in reset)
- in_data  in  8  pixel colour
- in_x  in  11  pixel column, unsigned
- in_y  in  11  pixel row, unsigned
- in_draw  in  1  1 = pixel is to be written; 0 = consume and discard
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- frame_start  in  1  one-cycle pulse; clears both counters
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  8  write data
- mem_we  out  1  write request valid
- mem_ready  in  1  memory accepts the write this cycle (transfer = mem_we & mem_ready)
- pixel_count  out  20  writes completed since last frame_start/reset
- drop_count  out  20  in-range-check failures since last frame_start/reset
- idle  out  1  FIFO empty and no write pending

## Operation
- Input accept: beat accepted when in_valid & in_ready. in_ready = !fifo_full & reset.
- Accepted beat classification (combinational, same cycle):
  - in_draw = 0 → discarded, no counter change.
  - in_draw = 1 and (in_x ≥ H_RES or in_y ≥ V_RES) → discarded, drop_count += 1.
  - otherwise → push {addr, in_data} into FIFO, addr = in_y*H_RES + in_x, truncated to ADDR_W. For default H_RES, multiply is shift-add: (y<<9)+(y<<8)+(y<<5); generic multiply acceptable for other values.
- FIFO: synchronous, FIFO_DEPTH entries of ADDR_W+8 bits, strict order. Read and write pointers one bit wider than index for full/empty.
- Output: mem_we = !fifo_empty; mem_addr/mem_wdata = FIFO head. Pop on mem_we & mem_ready. mem_addr/mem_wdata held stable while mem_we & !mem_ready.
- Counters: pixel_count += 1 per completed memory transfer; both counters saturate at 2^20-1. frame_start clears both; clear wins over a coinciding increment (that increment is lost). frame_start does not flush the FIFO.
- idle = fifo_empty.

## Timing
- Reset (reset = 0 at a rising edge): FIFO pointers 0, pixel_count 0, drop_count 0. While reset low: in_ready 0, mem_we 0, idle 1. First cycle after reset release: in_ready 1.
- Latency: beat accepted at edge N with FIFO empty → mem_we = 1 from cycle N+1 (after edge N) with that beat's address/data.
- Throughput: one beat per cycle sustained while mem_ready held high.
- Full: once FIFO_DEPTH entries pending, in_ready = 0. in_ready depends only on full: a pop in the same cycle does not allow a push; in_ready rises the cycle after the pop.
- Simultaneous push and pop on non-full, non-empty FIFO: occupancy unchanged, order preserved.
- Reset mid-operation: pending FIFO entries discarded, no further writes issued; mem_we drops in the reset cycle.
- Discarded beats (draw = 0 or off-screen) consume one input cycle and never reach the memory port.

## Test plan
- Single pixel: x=5, y=2, draw=1, data=0x3C, mem_ready=1 → one cycle later mem_we=1, mem_addr=1605, mem_wdata=0x3C; pixel_count=1; idle returns to 1.
- Filter: beats (x=10,y=0,draw=0), (x=800,y=0,draw=1), (x=0,y=600,draw=1), (x=799,y=599,draw=1,data=0xFF) → exactly one write, addr=479999, data=0xFF; drop_count=2, pixel_count=1.
- Back-pressure: mem_ready=0, 6 consecutive valid on-screen beats → 4 accepted, in_ready=0 after 4th; release mem_ready → 4 writes in order, then remaining 2 accepted and written; pixel_count=6.
- Hold stability: mem_ready toggled 0/1 every cycle during a 10-pixel burst → mem_addr/mem_wdata unchanged while stalled; all 10 written in order, no duplicates.
- frame_start coinciding with a completed write at pixel_count=7 → pixel_count=0 next cycle; FIFO contents still written afterwards and counted.
- Reset asserted with 3 entries pending → mem_we=0 in reset, no further writes after release, counters 0, in_ready=1 first cycle after release.
